// File: rtl/vga_tile_scanner.sv
// vga_tile_scanner: 640x480 raster scanner that publishes the current 16x16
// tile coordinate, takes back a draw flag and drives aligned sync + 9-bit RGB.
module vga_tile_scanner #(
  parameter int          H_ACTIVE     = 640,
  parameter int          H_FP         = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BP         = 48,
  parameter int          V_ACTIVE     = 480,
  parameter int          V_FP         = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BP         = 33,
  parameter int          TILE_SHIFT   = 4,
  parameter int          DRAW_LATENCY = 1,
  parameter logic [8:0]  FG_RGB       = 9'h1FF,
  parameter logic [8:0]  BG_RGB       = 9'h000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_draw,
  output logic [5:0] o_col,
  output logic [5:0] o_row,
  output logic       o_frame_start,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic [2:0] o_red,
  output logic [2:0] o_grn,
  output logic [2:0] o_blu
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS_C   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE_C   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST_C = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SS_C   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE_C   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST_C = 10'(V_TOTAL - 1);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;

  // Raster counters: h wraps each line, v advances on the h wrap.
  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST_C) begin
      h_cnt_d = 10'd0;
      v_cnt_d = (v_cnt_q == V_LAST_C) ? 10'd0 : v_cnt_q + 10'd1;
    end
  end

  // Counter state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      h_cnt_q <= 10'd0;
      v_cnt_q <= 10'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  logic active_s0, hs_s0, vs_s0;

  // Stage-0 decode straight off the counter registers, so tile outputs
  // always describe the pixel the counters currently point at.
  always_comb begin
    active_s0 = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    hs_s0     = !((h_cnt_q >= H_SS_C) && (h_cnt_q < H_SE_C));
    vs_s0     = !((v_cnt_q >= V_SS_C) && (v_cnt_q < V_SE_C));
  end

  // 6'h3F in blanking keeps objects parked at the grid edge from matching.
  assign o_col = (h_cnt_q < H_ACT_C) ? 6'(h_cnt_q >> TILE_SHIFT) : 6'h3F;
  assign o_row = (v_cnt_q < V_ACT_C) ? 6'(v_cnt_q >> TILE_SHIFT) : 6'h3F;
  assign o_frame_start = (h_cnt_q == 10'd0) && (v_cnt_q == V_ACT_C);

  // Delay line matching the game logic's draw latency; syncs idle high.
  logic [DRAW_LATENCY-1:0] act_q, act_d;
  logic [DRAW_LATENCY-1:0] hs_q,  hs_d;
  logic [DRAW_LATENCY-1:0] vs_q,  vs_d;

  genvar gi;
  generate
    for (gi = 0; gi < DRAW_LATENCY; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign act_d[gi] = active_s0;
        assign hs_d[gi]  = hs_s0;
        assign vs_d[gi]  = vs_s0;
      end else begin : g_next
        assign act_d[gi] = act_q[gi-1];
        assign hs_d[gi]  = hs_q[gi-1];
        assign vs_d[gi]  = vs_q[gi-1];
      end
    end
  endgenerate

  // Alignment shift register state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      act_q <= '0;
      hs_q  <= '1;
      vs_q  <= '1;
    end else begin
      act_q <= act_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  logic [8:0] rgb_q, rgb_d;
  logic       hsync_q, vsync_q;

  // Draw flag only matters inside the visible area; blanking is forced black.
  always_comb begin
    rgb_d = 9'h000;
    if (act_q[DRAW_LATENCY-1]) begin
      rgb_d = i_draw ? FG_RGB : BG_RGB;
    end
  end

  // Pin register: colour and syncs leave together.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rgb_q   <= 9'h000;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= hs_q[DRAW_LATENCY-1];
      vsync_q <= vs_q[DRAW_LATENCY-1];
    end
  end

  assign o_hsync = hsync_q;
  assign o_vsync = vsync_q;
  assign o_red   = rgb_q[8:6];
  assign o_grn   = rgb_q[5:3];
  assign o_blu   = rgb_q[2:0];

endmodule

// File: tb/tb_vga_tile_scanner.sv
// Bench: a full-size scanner and a shrunken-geometry scanner run side by side
// against a cycle-indexed raster model (pixel = k mod line, line = k / line).
module tb_vga_tile_scanner;

  typedef struct {
    int ha, hf, hs, ht;
    int va, vf, vs, vt;
    int bc, br;
  } geom_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic draw_s = 1'b0, draw_d = 1'b0;
  int   mode = 0;          // 0 ball, 1 constant draw, 2 random tile mask
  int   k = 0;             // cycles since counters last left reset
  int   vectors = 0;
  int   miscompares = 0;
  logic mask [0:29][0:39];

  logic [5:0] col_s, row_s, col_d, row_d;
  logic       fs_s, hs_s, vs_s, fs_d, hs_d, vs_d;
  logic [2:0] r_s, g_s, b_s, r_d, g_d, b_d;

  geom_t gs, gd;

  always #20 clk = ~clk;

  vga_tile_scanner #(
    .H_ACTIVE(160), .H_FP(8), .H_SYNC(16), .H_BP(16),
    .V_ACTIVE(64),  .V_FP(3), .V_SYNC(2),  .V_BP(6)
  ) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_draw(draw_s),
    .o_col(col_s), .o_row(row_s), .o_frame_start(fs_s),
    .o_hsync(hs_s), .o_vsync(vs_s),
    .o_red(r_s), .o_grn(g_s), .o_blu(b_s)
  );

  vga_tile_scanner dut_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_draw(draw_d),
    .o_col(col_d), .o_row(row_d), .o_frame_start(fs_d),
    .o_hsync(hs_d), .o_vsync(vs_d),
    .o_red(r_d), .o_grn(g_d), .o_blu(b_d)
  );

  function automatic logic draw_fn(input int m, input int c, input int r,
                                   input int bc, input int br);
    if (m == 0) return (c == bc) && (r == br);
    if (m == 1) return 1'b1;
    if (c < 40 && r < 30) return mask[r][c];
    return 1'b0;
  endfunction

  // Game-object stand-in: registered draw flag, one cycle after col/row.
  always @(posedge clk) begin
    draw_s <= draw_fn(mode, int'(col_s), int'(row_s), gs.bc, gs.br);
    draw_d <= draw_fn(mode, int'(col_d), int'(row_d), gd.bc, gd.br);
  end

  task automatic chk(input string nm, input string fld, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s.%s k=%0d observed=%0h expected=%0h", nm, fld, k, obs, exp);
    end
  endtask

  task automatic check_inst(input geom_t g, input string nm,
                            input logic [5:0] col, input logic [5:0] row,
                            input logic fs, input logic hs, input logic vs,
                            input logic [8:0] rgb);
    int h, v, p, hp, vp, ecol, erow, efs, ehs, evs, ergb;
    h = k % g.ht;
    v = (k / g.ht) % g.vt;
    ecol = (h < g.ha) ? h / 16 : 63;
    erow = (v < g.va) ? v / 16 : 63;
    efs  = (h == 0 && v == g.va) ? 1 : 0;
    p = k - 2;
    if (p < 0) begin
      ehs = 1; evs = 1; ergb = 0;
    end else begin
      hp = p % g.ht;
      vp = (p / g.ht) % g.vt;
      ehs = (hp >= g.ha + g.hf && hp < g.ha + g.hf + g.hs) ? 0 : 1;
      evs = (vp >= g.va + g.vf && vp < g.va + g.vf + g.vs) ? 0 : 1;
      ergb = (hp < g.ha && vp < g.va && draw_fn(mode, hp / 16, vp / 16, g.bc, g.br))
             ? 'h1FF : 0;
    end
    chk(nm, "col", int'(col), ecol);
    chk(nm, "row", int'(row), erow);
    chk(nm, "frame_start", int'(fs), efs);
    chk(nm, "hsync", int'(hs), ehs);
    chk(nm, "vsync", int'(vs), evs);
    chk(nm, "rgb", int'(rgb), ergb);
  endtask

  task automatic check_all();
    check_inst(gs, "small", col_s, row_s, fs_s, hs_s, vs_s, {r_s, g_s, b_s});
    check_inst(gd, "full",  col_d, row_d, fs_d, hs_d, vs_d, {r_d, g_d, b_d});
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      k++;
      check_all();
    end
  endtask

  // Assert reset on this negedge; the following cycle shows reset values.
  task automatic pulse_reset(input int new_mode);
    rst_n = 1'b0;
    mode  = new_mode;
    @(negedge clk);
    k = 0;
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    int run3;
    gs = '{ha:160, hf:8,  hs:16, ht:200, va:64,  vf:3,  vs:2, vt:75,  bc:5,  br:2};
    gd = '{ha:640, hf:16, hs:96, ht:800, va:480, vf:10, vs:2, vt:525, bc:20, br:1};
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 40; c++)
        mask[r][c] = 1'b0;

    // Power-up reset held a few cycles: every cycle shows reset values.
    rst_n = 1'b0;
    mode  = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      k = 0;
      check_all();
    end
    rst_n = 1'b1;

    // Ball phase: two full small frames, first 40 lines of the full raster.
    step_n(32300);

    // Mid-frame reset (full raster at line 40, pixel 300) with draw held high.
    pulse_reset(1);
    step_n(13200);

    // Random tile bitmap and a random run length.
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 40; c++)
        mask[r][c] = 1'($urandom_range(0, 1));
    pulse_reset(2);
    run3 = int'($urandom_range(3000, 6000));
    step_n(run3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
